// File: rtl/push_button_debounce.sv
// Debounces a raw, bouncy push button into a clean pressed level plus one-cycle
// press/release strobes, after a two-flop synchronizer and a stability interval.
module push_button_debounce #(
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH     = 20,
    parameter logic        PRESSED_LEVEL = 1'b0
) (
    input  logic osc_50,
    input  logic reset_n,
    input  logic push_button,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_CHECK_PRESS,
        ST_PRESSED,
        ST_CHECK_RELEASE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 w_btn_raw;
    logic                 r_s1;
    logic                 r_s2;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 r_pressed;
    logic                 w_pressed_nxt;
    logic                 r_press_pulse;
    logic                 w_press_pulse_nxt;
    logic                 r_release_pulse;
    logic                 w_release_pulse_nxt;

    // Normalized so that 1 always means pressed, whatever the board polarity.
    assign w_btn_raw = (push_button == PRESSED_LEVEL);

    always_ff @(posedge osc_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= w_btn_raw;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge osc_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_RELEASED;
            r_cnt           <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_pressed       <= w_pressed_nxt;
            r_press_pulse   <= w_press_pulse_nxt;
            r_release_pulse <= w_release_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_cnt_nxt           = r_cnt;
        w_pressed_nxt       = r_pressed;
        w_press_pulse_nxt   = 1'b0;
        w_release_pulse_nxt = 1'b0;
        case (r_state)
            ST_RELEASED: begin
                w_pressed_nxt = 1'b0;
                if (r_s2) begin
                    w_state_nxt = ST_CHECK_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CHECK_PRESS: begin
                w_pressed_nxt = 1'b0;
                if (!r_s2) begin
                    w_state_nxt = ST_RELEASED;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_nxt       = ST_PRESSED;
                    w_pressed_nxt     = 1'b1;
                    w_press_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_PRESSED: begin
                w_pressed_nxt = 1'b1;
                if (!r_s2) begin
                    w_state_nxt = ST_CHECK_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CHECK_RELEASE: begin
                w_pressed_nxt = 1'b1;
                if (r_s2) begin
                    w_state_nxt = ST_PRESSED;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_nxt         = ST_RELEASED;
                    w_pressed_nxt       = 1'b0;
                    w_release_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_RELEASED;
                w_cnt_nxt     = '0;
                w_pressed_nxt = 1'b0;
            end
        endcase
    end

    assign pressed       = r_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;

endmodule

// File: tb/tb_push_button_debounce.sv
// Bench for push_button_debounce: directed scenarios plus random button activity,
// each cycle compared against a run-length reference model of the debouncer.
module tb_push_button_debounce;

    localparam int STABLE = 4;
    localparam int LAT    = STABLE + 3;

    logic osc_50      = 1'b0;
    logic reset_n     = 1'b0;
    logic push_button = 1'b0;
    logic pressed;
    logic press_pulse;
    logic release_pulse;

    int n_chk  = 0;
    int n_fail = 0;
    int n_pp   = 0;
    int n_rp   = 0;

    // Reference model: synchronized-sample delay line plus a run length of
    // consecutive samples that disagree with the accepted level.
    bit m_d1, m_d2, m_p, m_pp, m_rp;
    int m_run;

    push_button_debounce #(
        .STABLE_CYCLES (STABLE),
        .CNT_WIDTH     (3),
        .PRESSED_LEVEL (1'b0)
    ) dut (
        .osc_50        (osc_50),
        .reset_n       (reset_n),
        .push_button   (push_button),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 osc_50 = ~osc_50;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit raw;
        raw = (push_button == 1'b0);
        @(posedge osc_50);
        if (!reset_n) begin
            m_d1 = 0; m_d2 = 0; m_p = 0; m_pp = 0; m_rp = 0; m_run = 0;
        end else begin
            m_pp = 0;
            m_rp = 0;
            if (m_d2 != m_p) m_run++;
            else m_run = 0;
            if (m_run == STABLE + 1) begin
                m_p   = ~m_p;
                m_pp  = m_p;
                m_rp  = ~m_p;
                m_run = 0;
            end
            m_d2 = m_d1;
            m_d1 = raw;
        end
        #1;
        check("pressed", pressed, m_p);
        check("press_pulse", press_pulse, m_pp);
        check("release_pulse", release_pulse, m_rp);
        if (press_pulse) n_pp++;
        if (release_pulse) n_rp++;
    endtask

    task automatic measure(input bit want_press, input int max, output int at);
        at = 0;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (at == 0 && (want_press ? press_pulse : release_pulse)) at = k;
        end
    endtask

    initial begin
        int at;
        int pp0, rp0;
        int len;

        // Reset held with the button pressed
        push_button = 1'b0;
        reset_n     = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        reset_n = 1'b1;
        measure(1'b1, 12, at);
        check_int("reset_release_press_latency", at, LAT);
        check_int("reset_release_press_count", n_pp, 1);

        // Clean release, press, hold, release
        push_button = 1'b1;
        measure(1'b0, 12, at);
        check_int("first_release_latency", at, LAT);
        push_button = 1'b0;
        measure(1'b1, 20, at);
        check_int("clean_press_latency", at, LAT);
        check("clean_press_held", pressed, 1'b1);
        push_button = 1'b1;
        measure(1'b0, 12, at);
        check_int("clean_release_latency", at, LAT);
        check("clean_release_level", pressed, 1'b0);

        // Bounce every 2 cycles, ending released
        pp0 = n_pp; rp0 = n_rp;
        for (int i = 0; i < 16; i++) begin
            push_button = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            tick();
        end
        for (int i = 0; i < 10; i++) tick();
        check_int("bounce_press_pulses", n_pp - pp0, 0);
        check_int("bounce_release_pulses", n_rp - rp0, 0);
        check("bounce_level", pressed, 1'b0);

        // Five single-cycle glitches, then settle pressed
        pp0 = n_pp;
        for (int i = 0; i < 5; i++) begin
            push_button = 1'b0; tick();
            push_button = 1'b1; tick();
        end
        push_button = 1'b0;
        measure(1'b1, 15, at);
        check_int("settle_press_latency", at, LAT);
        check_int("settle_press_count", n_pp - pp0, 1);

        // Back to released, then a 3-cycle press that must be ignored
        push_button = 1'b1;
        measure(1'b0, 12, at);
        check_int("settle_release_latency", at, LAT);
        pp0 = n_pp;
        push_button = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        push_button = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check_int("short_press_pulses", n_pp - pp0, 0);
        check("short_press_level", pressed, 1'b0);

        // Asynchronous reset while checking a release
        push_button = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("pre_async_pressed", pressed, 1'b1);
        push_button = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("in_check_release_pressed", pressed, 1'b1);
        rp0 = n_rp;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_pressed", pressed, 1'b0);
        check("async_reset_press_pulse", press_pulse, 1'b0);
        check("async_reset_release_pulse", release_pulse, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check_int("async_reset_release_pulses", n_rp - rp0, 0);
        check("after_async_level", pressed, 1'b0);

        // Random button activity with varied segment lengths
        for (int s = 0; s < 60; s++) begin
            push_button = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) tick();
        end
        push_button = 1'b1;
        for (int i = 0; i < 12; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
